// File: rtl/fp_normalize_left_if.sv
// Operand/result bundle for the post-add normaliser.
// Handshake: valid-only, no ready. in_valid marks a live operand in that cycle and is
// never stalled; out_valid marks a live result exactly 6 cycles later. Payload and flags
// are meaningful only while the matching valid is high.
interface fp_normalize_left_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
);
  logic             in_valid;
  logic [MAN_W+1:0] in_sum;
  logic [EXP_W-1:0] in_exp;
  logic             in_sign;
  logic             out_valid;
  logic [MAN_W-1:0] out_frac;
  logic [EXP_W-1:0] out_exp;
  logic             out_sign;
  logic             out_zero;
  logic             out_ovf;
  logic             out_unf;

  modport master (
    output in_valid, in_sum, in_exp, in_sign,
    input  out_valid, out_frac, out_exp, out_sign, out_zero, out_ovf, out_unf
  );

  modport slave (
    input  in_valid, in_sum, in_exp, in_sign,
    output out_valid, out_frac, out_exp, out_sign, out_zero, out_ovf, out_unf
  );
endinterface

// File: rtl/fp_normalize_left.sv
// Post-add normaliser: leading-one detect, 5-stage registered left barrel shift,
// exponent adjust and zero/overflow/underflow flush, fixed 6-cycle latency.
module fp_normalize_left #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                clk,
  input  logic                reset,
  fp_normalize_left_if.slave  bus
);
  // Five shift stages cover amounts up to 31, so MAN_W+1 must not exceed 32.
  localparam int SH_W = 5;
  localparam int LZ_W = $clog2(MAN_W + 2);
  localparam logic [EXP_W:0] EXP_MAX = {1'b0, {EXP_W{1'b1}}};

  typedef struct packed {
    logic             valid;
    logic             sign;
    logic             zero;
    logic             ovf;
    logic             unf;
    logic [SH_W-1:0]  shift;
    logic [EXP_W-1:0] exp;
    logic [MAN_W:0]   mant;
  } stage_t;

  logic [LZ_W-1:0] lz;
  logic [EXP_W:0]  exp_wide;
  logic [EXP_W:0]  lz_wide;
  logic [EXP_W:0]  exp_inc;
  logic [EXP_W:0]  exp_dec;
  stage_t          s0_d;
  stage_t          st_q [0:4];
  stage_t          s5;

  logic             out_valid_q;
  logic [MAN_W-1:0] out_frac_q;
  logic [EXP_W-1:0] out_exp_q;
  logic             out_sign_q;
  logic             out_zero_q;
  logic             out_ovf_q;
  logic             out_unf_q;

  // Upward scan: the highest set bit is the last one to overwrite lz.
  always_comb begin
    lz = LZ_W'(MAN_W + 1);
    for (int i = 0; i <= MAN_W; i++) begin
      if (bus.in_sum[i]) lz = LZ_W'(MAN_W - i);
    end
  end

  assign exp_wide = {1'b0, bus.in_exp};
  assign lz_wide  = (EXP_W+1)'(lz);
  assign exp_inc  = exp_wide + 1'b1;
  assign exp_dec  = exp_wide - lz_wide;

  always_comb begin
    s0_d       = '0;
    s0_d.valid = bus.in_valid;
    s0_d.sign  = bus.in_sign;
    if (bus.in_sum == '0) begin
      s0_d.zero = 1'b1;
    end else if (bus.in_sum[MAN_W+1]) begin
      s0_d.mant = bus.in_sum[MAN_W+1:1];
      s0_d.exp  = exp_inc[EXP_W-1:0];
      s0_d.ovf  = (exp_inc >= EXP_MAX);
    end else begin
      s0_d.mant  = bus.in_sum[MAN_W:0];
      s0_d.shift = SH_W'(lz);
      s0_d.exp   = exp_dec[EXP_W-1:0];
      s0_d.unf   = (exp_wide <= lz_wide);
    end
  end

  function automatic stage_t shift_step(input stage_t s, input int k);
    stage_t r;
    r = s;
    if (s.shift[k]) r.mant = s.mant << (1 << k);
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 5; i++) st_q[i] <= '0;
    end else begin
      st_q[0] <= s0_d;
      for (int k = 1; k < 5; k++) st_q[k] <= shift_step(st_q[k-1], k - 1);
    end
  end

  // The 16-bit shift folds into the output register to keep latency at 6.
  assign s5 = shift_step(st_q[4], 4);

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_frac_q  <= '0;
      out_exp_q   <= '0;
      out_sign_q  <= 1'b0;
      out_zero_q  <= 1'b0;
      out_ovf_q   <= 1'b0;
      out_unf_q   <= 1'b0;
    end else begin
      out_valid_q <= s5.valid;
      out_sign_q  <= s5.sign;
      out_zero_q  <= s5.zero;
      out_ovf_q   <= s5.ovf & ~s5.zero;
      out_unf_q   <= s5.unf & ~s5.zero & ~s5.ovf;
      if (s5.zero) begin
        out_frac_q <= '0;
        out_exp_q  <= '0;
      end else if (s5.ovf) begin
        out_frac_q <= '0;
        out_exp_q  <= '1;
      end else if (s5.unf) begin
        out_frac_q <= '0;
        out_exp_q  <= '0;
      end else begin
        out_frac_q <= s5.mant[MAN_W-1:0];
        out_exp_q  <= s5.exp;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_frac  = out_frac_q;
  assign bus.out_exp   = out_exp_q;
  assign bus.out_sign  = out_sign_q;
  assign bus.out_zero  = out_zero_q;
  assign bus.out_ovf   = out_ovf_q;
  assign bus.out_unf   = out_unf_q;
endmodule

// File: tb/tb_fp_normalize_left.sv
// Bench for fp_normalize_left: directed cases, random bursts and mid-stream reset,
// checked through an expected-result queue against an arithmetic reference model.
module tb_fp_normalize_left;
  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int W     = MAN_W + EXP_W + 4;
  localparam int LAT   = 6;

  logic clk;
  logic reset;
  int   cyc;
  int   n_checks;
  int   n_pass;

  logic [W-1:0] exp_q[$];
  int           iss_q[$];

  fp_normalize_left_if #(.EXP_W(EXP_W), .MAN_W(MAN_W)) bus ();

  fp_normalize_left #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, req);
  endtask

  // Reference: plain integer arithmetic on the value of the sum.
  function automatic logic [W-1:0] ref_model(input longint sum, input int e, input bit sign);
    longint hid;
    longint frac;
    int     ee;
    int     p;
    int     lzc;
    bit     z, o, u;
    hid  = longint'(1) << MAN_W;
    frac = 0;
    ee   = 0;
    z    = 0;
    o    = 0;
    u    = 0;
    if (sum == 0) begin
      z = 1;
    end else if (sum >= 2 * hid) begin
      ee = e + 1;
      if (ee >= (1 << EXP_W) - 1) begin
        o  = 1;
        ee = (1 << EXP_W) - 1;
      end else begin
        frac = sum / 2 - hid;
      end
    end else begin
      p = MAN_W;
      while (sum < (longint'(1) << p)) p--;
      lzc = MAN_W - p;
      ee  = e - lzc;
      if (ee <= 0) begin
        u  = 1;
        ee = 0;
      end else begin
        frac = (sum << lzc) - hid;
      end
    end
    return {sign, z, o, u, EXP_W'(ee), MAN_W'(frac)};
  endfunction

  // driver
  task automatic send(input logic [MAN_W+1:0] sum, input logic [EXP_W-1:0] e, input bit s);
    bus.in_valid = 1'b1;
    bus.in_sum   = sum;
    bus.in_exp   = e;
    bus.in_sign  = s;
    exp_q.push_back(ref_model(longint'(sum), int'(e), s));
    iss_q.push_back(cyc);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_random();
    int          w;
    longint      v;
    logic [MAN_W+1:0] sum;
    w   = $urandom_range(0, MAN_W + 2);
    v   = (longint'($urandom) << 32) | longint'($urandom);
    sum = (MAN_W+2)'(v & ((longint'(1) << w) - 1));
    case ($urandom_range(0, 5))
      0:       send(sum, EXP_W'($urandom_range(250, 255)), 1'($urandom));
      1:       send(sum, EXP_W'($urandom_range(0, 30)), 1'($urandom));
      default: send(sum, EXP_W'($urandom_range(0, 255)), 1'($urandom));
    endcase
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (!reset && bus.out_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 64'(bus.out_valid), 64'd0);
      end else begin
        logic [W-1:0] e;
        int           t;
        e = exp_q.pop_front();
        t = iss_q.pop_front();
        check("result", 64'({bus.out_sign, bus.out_zero, bus.out_ovf, bus.out_unf,
                             bus.out_exp, bus.out_frac}), 64'(e));
        check("latency", 64'(cyc - t), 64'(LAT));
      end
    end
  end

  initial begin
    n_checks     = 0;
    n_pass       = 0;
    cyc          = 0;
    reset        = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_sum   = '1;
    bus.in_exp   = '1;
    bus.in_sign  = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", 64'({bus.out_valid, bus.out_sign, bus.out_zero, bus.out_ovf,
                                bus.out_unf, bus.out_exp, bus.out_frac}), 64'd0);
    #1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle(2);

    // directed
    send(25'h1800000, 8'h7F, 1'b0);
    send(25'h0C00000, 8'h81, 1'b1);
    send(25'h0000001, 8'h40, 1'b0);
    send(25'h0000001, 8'h17, 1'b1);
    send(25'h0000000, 8'h55, 1'b0);
    send(25'h1000000, 8'hFE, 1'b1);
    send(25'h1000000, 8'hFD, 1'b0);
    send(25'h0000002, 8'h17, 1'b0);
    send(25'h1FFFFFF, 8'h00, 1'b1);
    drain();
    check("ref_case1", 64'(ref_model(64'h1800000, 32'h7F, 1'b0)),
          64'({1'b0, 3'b000, 8'h80, 23'h400000}));

    // throughput: back-to-back random
    repeat (20) send_random();
    drain();
    idle(3);
    repeat (40) begin
      send_random();
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    drain();

    // reset mid-stream: in-flight ops must vanish
    repeat (3) send_random();
    reset        = 1'b1;
    exp_q.delete();
    iss_q.delete();
    bus.in_valid = 1'b1;
    bus.in_sum   = 25'h0C00000;
    bus.in_exp   = 8'h40;
    bus.in_sign  = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("midreset_outputs", 64'({bus.out_valid, bus.out_sign, bus.out_zero, bus.out_ovf,
                                   bus.out_unf, bus.out_exp, bus.out_frac}), 64'd0);
    #1;
    bus.in_valid = 1'b0;
    reset        = 1'b0;
    idle(12);
    check("post_reset_queue", 64'(exp_q.size()), 64'd0);

    repeat (10) send_random();
    drain();
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
